// File: rtl/irq_pkg.sv
// irq_pkg: shared constants, FSM state type and priority function for the interrupt arbiter
package irq_pkg;
    localparam int N_SRC = 8;
    localparam int IDX_W = 3;

    typedef enum logic {IDLE, PRESENT} state_t;

    // Highest set index wins; all-zero input yields 0, which callers never register
    function automatic logic [IDX_W-1:0] prio_idx(input logic [N_SRC-1:0] vec);
        prio_idx = '0;
        for (int i = 0; i < N_SRC; i++)
            if (vec[i]) prio_idx = IDX_W'(i);
    endfunction
endpackage

// File: rtl/irq_sync_edge.sv
// irq_sync_edge: multi-flop synchroniser for one async request line plus rising-edge detector
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_prev;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sync_q    <= '0;
            sync_prev <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], d};
            sync_prev <= sync_q[SYNC_STAGES-1];
        end

    assign rise = sync_q[SYNC_STAGES-1] & ~sync_prev;
endmodule

// File: rtl/irq_pending_arbiter.sv
// irq_pending_arbiter: sticky pending capture of synchronised irq edges, masked priority
// selection and a registered valid/ack handshake towards the encoder stage
module irq_pending_arbiter
    import irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] irq_in,
    input  logic [N_SRC-1:0] irq_mask,
    input  logic             irq_ack,
    output logic             irq_valid,
    output logic [IDX_W-1:0] irq_id,
    output logic [N_SRC-1:0] pending
);
    logic [N_SRC-1:0] rise, clr, eligible;
    state_t           state, state_nx;

    genvar i;
    for (i = 0; i < N_SRC; i++) begin : g_src
        irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk  (clk),
            .rst_n(rst_n),
            .d    (irq_in[i]),
            .rise (rise[i])
        );
    end

    assign eligible = pending & irq_mask;
    assign clr      = (state == PRESENT && irq_ack) ? N_SRC'(1) << irq_id : '0;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    always_comb
        state_nx = (state == IDLE) ? ((|eligible) ? PRESENT : IDLE)
                                   : (irq_ack ? IDLE : PRESENT);

    always_comb irq_valid = (state == PRESENT);

    // Set wins over clear so a fresh edge on the acked source is not lost
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pending <= '0;
            irq_id  <= '0;
        end else begin
            pending <= (pending & ~clr) | rise;
            if (state == IDLE && |eligible) irq_id <= prio_idx(eligible);
        end
endmodule

// File: tb/tb_irq_pending_arbiter.sv
// tb_irq_pending_arbiter: directed checks of capture latency, priority, hold, masking and reset
module tb_irq_pending_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] irq_in = 8'h00;
    logic [7:0] irq_mask = 8'hFF;
    logic       irq_ack = 1'b0;
    logic       irq_valid;
    logic [2:0] irq_id;
    logic [7:0] pending;
    int         checks = 0;
    int         failures = 0;

    irq_pending_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .irq_in   (irq_in),
        .irq_mask (irq_mask),
        .irq_ack  (irq_ack),
        .irq_valid(irq_valid),
        .irq_id   (irq_id),
        .pending  (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        check("rst_valid", {7'd0, irq_valid}, 8'd0);
        check("rst_id", {5'd0, irq_id}, 8'd0);
        check("rst_pend", pending, 8'h00);
        rst_n = 1'b1;
        tick(1);

        // 1: single source latency and ack
        irq_in = 8'h20;
        tick(3);
        check("t1_pend_e3", pending, 8'h20);
        check("t1_valid_e3", {7'd0, irq_valid}, 8'd0);
        tick(1);
        check("t1_valid_e4", {7'd0, irq_valid}, 8'd1);
        check("t1_id", {5'd0, irq_id}, 8'd5);
        irq_in = 8'h00;
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
        check("t1_ack_valid", {7'd0, irq_valid}, 8'd0);
        check("t1_ack_pend", pending, 8'h00);
        tick(3);

        // 2: simultaneous 2 and 6
        irq_in = 8'h44;
        tick(4);
        check("t2_pend", pending, 8'h44);
        check("t2_id6", {5'd0, irq_id}, 8'd6);
        check("t2_valid6", {7'd0, irq_valid}, 8'd1);
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
        check("t2_gap_valid", {7'd0, irq_valid}, 8'd0);
        check("t2_gap_pend", pending, 8'h04);
        tick(1);
        check("t2_valid2", {7'd0, irq_valid}, 8'd1);
        check("t2_id2", {5'd0, irq_id}, 8'd2);
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
        check("t2_pend_clr", pending, 8'h00);
        irq_in = 8'h00;
        tick(3);

        // 3: no preemption
        irq_in = 8'h02;
        tick(4);
        check("t3_id1", {5'd0, irq_id}, 8'd1);
        irq_in = 8'h82;
        tick(4);
        check("t3_pend", pending, 8'h82);
        check("t3_hold_id", {5'd0, irq_id}, 8'd1);
        check("t3_hold_valid", {7'd0, irq_valid}, 8'd1);
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
        check("t3_gap_valid", {7'd0, irq_valid}, 8'd0);
        tick(1);
        check("t3_id7", {5'd0, irq_id}, 8'd7);
        check("t3_valid7", {7'd0, irq_valid}, 8'd1);
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
        irq_in = 8'h00;
        tick(3);

        // 4: masked capture
        irq_mask = 8'h0F;
        irq_in = 8'h10;
        tick(4);
        check("t4_pend", pending, 8'h10);
        check("t4_masked_valid", {7'd0, irq_valid}, 8'd0);
        irq_mask = 8'hFF;
        tick(2);
        check("t4_valid", {7'd0, irq_valid}, 8'd1);
        check("t4_id", {5'd0, irq_id}, 8'd4);
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
        irq_in = 8'h00;
        tick(3);

        // 5: same-cycle ack and re-edge, then ack while idle
        irq_in = 8'h08;
        tick(4);
        check("t5_id3", {5'd0, irq_id}, 8'd3);
        irq_in = 8'h00;
        tick(3);
        irq_in = 8'h08;
        tick(2);
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
        check("t5_set_wins", pending, 8'h08);
        check("t5_gap_valid", {7'd0, irq_valid}, 8'd0);
        tick(1);
        check("t5_regrant_valid", {7'd0, irq_valid}, 8'd1);
        check("t5_regrant_id", {5'd0, irq_id}, 8'd3);
        irq_ack = 1'b1;
        tick(1);
        check("t5_clr", pending, 8'h00);
        tick(1);
        irq_ack = 1'b0;
        check("t5_idle_ack_valid", {7'd0, irq_valid}, 8'd0);
        check("t5_idle_ack_pend", pending, 8'h00);
        irq_in = 8'h00;
        tick(3);

        // 6: async reset mid-PRESENT, release with line held high
        irq_in = 8'h04;
        tick(4);
        check("t6_pre_id", {5'd0, irq_id}, 8'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_valid", {7'd0, irq_valid}, 8'd0);
        check("t6_async_id", {5'd0, irq_id}, 8'd0);
        check("t6_async_pend", pending, 8'h00);
        irq_in = 8'h01;
        tick(3);
        rst_n = 1'b1;
        tick(3);
        check("t6_rel_pend", pending, 8'h01);
        check("t6_rel_valid_e3", {7'd0, irq_valid}, 8'd0);
        tick(1);
        check("t6_rel_valid", {7'd0, irq_valid}, 8'd1);
        check("t6_rel_id", {5'd0, irq_id}, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
